// File: rtl/skid_pipeline_reg_pkg.sv
// Shared pipeline definitions: stage state encoding and the MEM/WB
// payload layout carried through the skid register.
package skid_pipeline_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  localparam int MEMWB_W = 136;

  // MEM/WB field offsets, LSB first
  localparam int MW_WB_SEL_LSB = 0;
  localparam int MW_WB_SEL_W   = 2;
  localparam int MW_DEST_LSB   = 2;
  localparam int MW_DEST_W     = 5;
  localparam int MW_IMM_LSB    = 7;
  localparam int MW_ALU_LSB    = 39;
  localparam int MW_MEMD_LSB   = 71;
  localparam int MW_PC_LSB     = 103;
  localparam int MW_WORD_W     = 32;
  localparam int MW_REGW_BIT   = 135;

  typedef struct packed {
    logic        reg_write;
    logic [31:0] pc;
    logic [31:0] mem_data;
    logic [31:0] alu_result;
    logic [31:0] imm;
    logic [4:0]  dest_addr;
    logic [1:0]  wb_sel;
  } mem_wb_t;

  function automatic logic [1:0] occ_of(input skid_state_e s);
    logic [1:0] n;
    n = 2'd0;
    unique case (s)
      ST_EMPTY: n = 2'd0;
      ST_BUSY:  n = 2'd1;
      ST_FULL:  n = 2'd2;
      default:  n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/skid_pipeline_reg.sv
// Two-entry skid pipeline register: fully registered in_ready and
// out_data, one-cycle latency, flush kills both entries.
module skid_pipeline_reg
  import skid_pipeline_reg_pkg::*;
#(
  parameter int DATA_W        = 136,
  parameter bit ZERO_ON_FLUSH = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  skid_state_e       r_state;
  skid_state_e       w_state_nxt;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;

  logic w_in_xfer;
  logic w_out_xfer;
  logic w_ld_main;
  logic w_main_from_skid;
  logic w_ld_skid;

  assign in_ready   = (r_state != ST_FULL);
  assign out_valid  = (r_state != ST_EMPTY);
  assign out_data   = r_main;
  assign occupancy  = occ_of(r_state);
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_ld_main        = 1'b0;
    w_main_from_skid = 1'b0;
    w_ld_skid        = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            w_ld_main   = 1'b1;
            w_state_nxt = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_in_xfer && w_out_xfer) begin
            w_ld_main = 1'b1;
          end else if (w_in_xfer) begin
            w_ld_skid   = 1'b1;
            w_state_nxt = ST_FULL;
          end else if (w_out_xfer) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_out_xfer) begin
            w_ld_main        = 1'b1;
            w_main_from_skid = 1'b1;
            w_state_nxt      = ST_BUSY;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Payload only moves on an explicit load, keeping held outputs stable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main <= '0;
      r_skid <= '0;
    end else if (flush) begin
      if (ZERO_ON_FLUSH) begin
        r_main <= '0;
        r_skid <= '0;
      end
    end else begin
      if (w_ld_main) r_main <= w_main_from_skid ? r_skid : in_data;
      if (w_ld_skid) r_skid <= in_data;
    end
  end

endmodule

// File: tb/tb_skid_pipeline_reg.sv
// Directed and random checks of skid_pipeline_reg against a queue
// model of the stage contents.
module tb_skid_pipeline_reg;
  localparam int W = 136;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  int n_vec;
  int n_err;
  logic [W-1:0] sb[$];

  skid_pipeline_reg #(.DATA_W(W), .ZERO_ON_FLUSH(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int n;
    n = sb.size();
    check({tag, ".ovalid"}, W'(out_valid), W'(n != 0));
    check({tag, ".iready"}, W'(in_ready), W'(n != 2));
    check({tag, ".occ"}, W'(occupancy), W'(n));
    if (n != 0) check({tag, ".odata"}, out_data, sb[0]);
  endtask

  // One clock: record transfers before the edge, update model after it
  task automatic tick(input string tag);
    logic         ix;
    logic         ox;
    logic [W-1:0] od;
    logic [W-1:0] e;
    ix = in_valid & in_ready;
    ox = out_valid & out_ready;
    od = out_data;
    @(posedge clk);
    #1;
    if (flush) begin
      sb.delete();
    end else begin
      if (ox) begin
        if (sb.size() == 0) begin
          check({tag, ".spurious"}, W'(1), W'(0));
        end else begin
          e = sb.pop_front();
          check({tag, ".pop"}, od, e);
        end
      end
      if (ix) sb.push_back(in_data);
    end
    check_state(tag);
  endtask

  function automatic logic [W-1:0] rnd_word();
    return {$urandom(), $urandom(), $urandom(), $urandom(), 8'($urandom())};
  endfunction

  initial begin
    logic r0;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    #12;
    check("rst.ovalid", W'(out_valid), W'(0));
    check("rst.odata", out_data, W'(0));
    check("rst.occ", W'(occupancy), W'(0));
    check("rst.iready", W'(in_ready), W'(1));
    rst = 1'b0;
    @(negedge clk);

    // single beat, one-cycle latency
    in_valid = 1'b1;
    in_data = W'(8'hA5);
    out_ready = 1'b1;
    tick("a5");
    check("a5.data", out_data, W'(8'hA5));
    check("a5.occ1", W'(occupancy), W'(1));
    in_valid = 1'b0;
    tick("a5drain");
    check("a5.empty", W'(out_valid), W'(0));

    // fill to FULL under backpressure, then drain in order
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = W'(8'h11);
    tick("fill1");
    in_data = W'(8'h22);
    tick("fill2");
    check("full.occ", W'(occupancy), W'(2));
    check("full.iready", W'(in_ready), W'(0));
    in_data = W'(8'h99);
    tick("fullhold");
    check("full.held", out_data, W'(8'h11));
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick("drain1");
    check("drain1.data", out_data, W'(8'h22));
    tick("drain2");
    check("drain2.empty", W'(out_valid), W'(0));

    // streaming 1..100 with no bubbles
    in_valid = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      in_data = W'(i);
      tick("stream");
    end
    in_valid = 1'b0;
    tick("streamend");
    check("stream.empty", W'(out_valid), W'(0));

    // flush from FULL with a competing input
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = W'(8'h33);
    tick("f33");
    in_data = W'(8'h44);
    tick("f44");
    flush = 1'b1;
    in_data = W'(8'h55);
    tick("flush");
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush.ovalid", W'(out_valid), W'(0));
    check("flush.odata", out_data, W'(0));
    check("flush.occ", W'(occupancy), W'(0));
    out_ready = 1'b1;
    tick("postflush");
    check("postflush.ovalid", W'(out_valid), W'(0));

    // asynchronous reset while BUSY
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = W'(8'h77);
    tick("busy77");
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst.ovalid", W'(out_valid), W'(0));
    check("arst.odata", out_data, W'(0));
    check("arst.iready", W'(in_ready), W'(1));
    check("arst.occ", W'(occupancy), W'(0));
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1;
    in_data = W'(8'h66);
    out_ready = 1'b1;
    tick("postrst");
    check("postrst.data", out_data, W'(8'h66));

    // random traffic against the scoreboard
    for (int i = 0; i < 10000; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = rnd_word();
      out_ready = ($urandom_range(0, 3) != 0);
      r0 = in_ready;
      out_ready = ~out_ready;
      #1;
      check("rnd.indep", W'(in_ready), W'(r0));
      out_ready = ~out_ready;
      tick("rnd");
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick("fin1");
    tick("fin2");
    check("fin.empty", W'(sb.size()), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/skid_pipeline_reg.md
SKID_PIPELINE_REG -- requirements
Module: skid_pipeline_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 136, stage payload width (MEM/WB bundle: reg_write, pc, mem_data, alu_result, imm, dest_addr, wb_sel).
REQ-002 SHALL have parameter ZERO_ON_FLUSH, default 1; when 1, flush clears the payload registers to zero.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port flush  input  1  synchronous kill of stage contents.
REQ-006 SHALL have port in_valid  input  1  upstream payload valid.
REQ-007 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-008 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-009 SHALL have port out_valid  output  1  out_data holds a live instruction.
REQ-010 SHALL have port out_ready  input  1  downstream accepts; tie to !busywait.
REQ-011 SHALL have port out_data  output  DATA_W  registered payload to downstream.
REQ-012 SHALL have port occupancy  output  2  live entries held (0..2).

Function
REQ-013 SHALL hold two registers, main (drives out_data) and skid, plus a state register: EMPTY, BUSY (main live), FULL (main and skid live).
REQ-014 SHALL drive in_ready = (state != FULL), decoded from the state register only; no combinational path from out_ready or in_valid to in_ready.
REQ-015 SHALL drive out_valid = (state != EMPTY); out_data = main, no combinational path from in_data.
REQ-016 SHALL count a transfer as in_valid & in_ready (input) or out_valid & out_ready (output).
REQ-017 EMPTY: input transfer -> main <= in_data, BUSY; otherwise stay.
REQ-018 BUSY: input and output transfers together -> main <= in_data, stay BUSY; input only -> skid <= in_data, FULL; output only -> EMPTY; neither -> hold.
REQ-019 FULL: output transfer -> main <= skid, BUSY; otherwise hold; no input accepted.
REQ-020 SHALL give latency of exactly one cycle from input transfer to out_valid when the stage was EMPTY or was BUSY with a simultaneous output transfer.
REQ-021 SHALL never drop or duplicate a payload; order preserved (main drains before skid).
REQ-022 flush SHALL have priority over all transfers: next state EMPTY, and the input transfer in the flush cycle is consumed and discarded.
REQ-023 With ZERO_ON_FLUSH=1, flush SHALL zero main and skid; with 0, payload registers hold their values and only state changes.
REQ-024 occupancy SHALL equal 0/1/2 for EMPTY/BUSY/FULL.
REQ-025 Payload registers SHALL not change on cycles without a load, so a held output is bit-stable while out_ready is low.

Reset
REQ-026 rst SHALL asynchronously force state EMPTY, main and skid zero, giving out_valid=0, out_data=0, occupancy=0, in_ready=1.
REQ-027 rst asserted mid-operation SHALL discard both entries immediately; the first rising edge after deassertion behaves as EMPTY.
REQ-028 No output SHALL be X after reset for any parameter value.

Structure
REQ-029 State encoding (EMPTY=2'd0, BUSY=2'd1, FULL=2'd2) and MEM/WB payload field offsets SHALL live in the shared pipeline package.
REQ-030 SHALL be one module with no sub-modules; the MEM/WB stage is an instance with DATA_W=136 and out_ready=!busywait.

Verification
REQ-031 Reset then in_valid=1, in_data=0xA5 (low bits), out_ready=1 -> out_valid=1 with out_data=0xA5 one edge later; occupancy=1.
REQ-032 out_ready=0, feed 0x11 then 0x22 -> occupancy=2, in_ready=0, out_data=0x11 held; raise out_ready -> 0x11 then 0x22 on successive cycles, then out_valid=0.
REQ-033 Continuous in_valid/out_ready=1 with counter payload 1..100 -> output stream 1..100 in order, no gaps after the first cycle.
REQ-034 FULL with 0x33/0x44, assert flush one cycle with in_valid=1, in_data=0x55 -> state EMPTY, out_valid=0, out_data=0, 0x55 never emitted.
REQ-035 Assert rst asynchronously between edges while BUSY -> out_valid and out_data drop to 0 before the next edge; in_ready=1.
REQ-036 Random in_valid/out_ready (≥10k cycles) against a scoreboard -> no loss, duplication or reordering; in_ready never depends on same-cycle out_ready.
